// File: rtl/bp_window_peak_detector_pkg.sv
// Shared types and helpers for the band-pass window peak detector.
// Optional macro BP_PEAK_MEAN_EN adds the window mean to the result record.
package bp_meas_pkg;

    localparam int BP_DATA_W = 12;
    localparam int CMP_W     = 32;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    typedef struct packed {
        logic signed [BP_DATA_W-1:0] max;
        logic signed [BP_DATA_W-1:0] min;
        logic        [BP_DATA_W:0]   pp;
`ifdef BP_PEAK_MEAN_EN
        logic signed [BP_DATA_W-1:0] mean;
`endif
    } bp_peak_rec_t;

    // Compare on a wide signed type; callers sign-extend in and truncate out.
    function automatic logic signed [CMP_W-1:0] signed_max(
        input logic signed [CMP_W-1:0] a,
        input logic signed [CMP_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [CMP_W-1:0] signed_min(
        input logic signed [CMP_W-1:0] a,
        input logic signed [CMP_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bp_window_peak_detector_if.sv
// Sample stream and result record interfaces for the peak detector.
// Result carries m_mean only when BP_PEAK_MEAN_EN is defined.
interface bp_sample_if #(
    parameter int DATA_W = 12
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

interface bp_result_if #(
    parameter int DATA_W = 12
);
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_max;
    logic signed [DATA_W-1:0] m_min;
    logic        [DATA_W:0]   m_pp;
`ifdef BP_PEAK_MEAN_EN
    logic signed [DATA_W-1:0] m_mean;
`endif

`ifdef BP_PEAK_MEAN_EN
    modport master (output m_valid, m_max, m_min, m_pp, m_mean, input m_ready);
    modport slave  (input  m_valid, m_max, m_min, m_pp, m_mean, output m_ready);
`else
    modport master (output m_valid, m_max, m_min, m_pp, input m_ready);
    modport slave  (input  m_valid, m_max, m_min, m_pp, output m_ready);
`endif
endinterface

// File: rtl/bp_window_peak_detector_out_reg.sv
// One-deep valid/ready output register for a window result record.
// Ports: clk, rst_n, i_load/i_rec (new record), i_ready, o_valid/o_rec.
import bp_meas_pkg::*;

module bp_peak_out_reg #(
    parameter type rec_t = bp_peak_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  rec_t i_rec,
    input  logic i_ready,
    output logic o_valid,
    output rec_t o_rec
);

    logic r_valid;
    rec_t r_rec;

    // A load in the same cycle as a pop keeps valid high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rec   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rec   <= i_rec;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_rec   = r_rec;

endmodule

// File: rtl/bp_window_peak_detector.sv
// Per-window max/min/peak-to-peak of band-pass ADC samples.
// Ports: clk, rst_n, enable, s (sample stream), m (result), busy.
// Optional macro BP_PEAK_MEAN_EN adds the signed window mean m_mean.
import bp_meas_pkg::*;

module bp_window_peak_detector #(
    parameter int DATA_W  = 12,
    parameter int WIN_LEN = 256,
    parameter int CNT_W   = $clog2(WIN_LEN)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enable,
    bp_sample_if.slave s,
    bp_result_if.master m,
    output logic      busy
);

    typedef struct packed {
        logic signed [DATA_W-1:0] max;
        logic signed [DATA_W-1:0] min;
        logic        [DATA_W:0]   pp;
`ifdef BP_PEAK_MEAN_EN
        logic signed [DATA_W-1:0] mean;
`endif
    } rec_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_max;
    logic signed [DATA_W-1:0] r_min;
    logic signed [DATA_W-1:0] w_max_nxt;
    logic signed [DATA_W-1:0] w_min_nxt;
    logic                     w_sready;
    logic                     w_accept;
    logic                     w_first;
    logic                     w_last;
    logic                     w_close;
    logic                     w_ovalid;
    rec_t                     w_rec;
    rec_t                     w_orec;

    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CNT_W'(WIN_LEN - 1));
    assign w_accept = s.s_valid && w_sready;
    assign w_close  = w_accept && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Hold off the final sample only while the previous record is stuck;
    // this keeps the one-deep output from ever being overwritten.
    always_comb begin
        w_state_nxt = r_state;
        w_sready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                w_sready = !(w_last && w_ovalid && !m.m_ready);
                if (!enable) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_max_nxt = w_first ? s.s_data :
        DATA_W'(signed_max(CMP_W'(r_max), CMP_W'(s.s_data)));
    assign w_min_nxt = w_first ? s.s_data :
        DATA_W'(signed_min(CMP_W'(r_min), CMP_W'(s.s_data)));

`ifdef BP_PEAK_MEAN_EN
    localparam int ACC_W = DATA_W + CNT_W;

    if ((1 << CNT_W) != WIN_LEN) begin : g_len_chk
        $error("WIN_LEN must be a power of two for the mean");
    end

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;

    assign w_acc_nxt = w_first ? ACC_W'(s.s_data) :
        r_acc + ACC_W'(s.s_data);
    assign w_rec.mean = DATA_W'(w_acc_nxt >>> CNT_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_acc <= '0;
        else if (r_state == ACCUM && !enable) r_acc <= '0;
        else if (w_accept)                   r_acc <= w_acc_nxt;
    end
`endif

    assign w_rec.max = w_max_nxt;
    assign w_rec.min = w_min_nxt;
    // One extra bit so full-scale swings cannot wrap.
    assign w_rec.pp  = {w_max_nxt[DATA_W-1], w_max_nxt}
                     - {w_min_nxt[DATA_W-1], w_min_nxt};

    // Disable discards the partial window; a closing accept still loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_max <= '0;
            r_min <= '0;
        end else if (r_state == ACCUM && !enable) begin
            r_cnt <= '0;
            r_max <= '0;
            r_min <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
        end
    end

    bp_peak_out_reg #(
        .rec_t (rec_t)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_close),
        .i_rec   (w_rec),
        .i_ready (m.m_ready),
        .o_valid (w_ovalid),
        .o_rec   (w_orec)
    );

    assign s.s_ready = w_sready;
    assign m.m_valid = w_ovalid;
    assign m.m_max   = w_orec.max;
    assign m.m_min   = w_orec.min;
    assign m.m_pp    = w_orec.pp;
`ifdef BP_PEAK_MEAN_EN
    assign m.m_mean  = w_orec.mean;
`endif
    assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_bp_window_peak_detector.sv
// Directed bench for bp_window_peak_detector, WIN_LEN=4, DATA_W=12.
// Checks m_mean as well when BP_PEAK_MEAN_EN is defined.
module tb_bp_window_peak_detector;

    localparam int DW = 12;
    localparam int WL = 4;

    logic clk;
    logic rst_n;
    logic enable;
    logic busy;

    bp_sample_if #(.DATA_W(DW)) s_if ();
    bp_result_if #(.DATA_W(DW)) m_if ();

    bp_window_peak_detector #(
        .DATA_W  (DW),
        .WIN_LEN (WL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .s      (s_if),
        .m      (m_if),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int smp[4];
        int emax;
        int emin;
        int epp;
        int emean;
    } vec_t;

    vec_t vec[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int emax, input int emin,
                           input int epp, input int emean);
        chk({tag, ".valid"}, int'(m_if.m_valid), 1);
        chk({tag, ".max"}, int'(m_if.m_max), emax);
        chk({tag, ".min"}, int'(m_if.m_min), emin);
        chk({tag, ".pp"}, int'(m_if.m_pp), epp);
`ifdef BP_PEAK_MEAN_EN
        chk({tag, ".mean"}, int'(m_if.m_mean), emean);
`else
        if (emean == 32'h7fff_ffff) $display("unused mean %0d", emean);
`endif
    endtask

    // Present one sample and hold it until the DUT takes it.
    task automatic push(input int v);
        int n;
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = DW'(v);
        n = 0;
        while (!s_if.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got s_ready=0 expected 1");
        end
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
    endtask

    initial begin
        vec[0] = '{'{10, -3, 7, 0}, 10, -3, 13, 3};
        vec[1] = '{'{2047, -2048, 0, 0}, 2047, -2048, 4095, -1};
        vec[2] = '{'{-5, -5, -5, -5}, -5, -5, 0, -5};
        vec[3] = '{'{-2048, -1, -100, -7}, -1, -2048, 2047, -539};
        vec[4] = '{'{1, 2, 3, 4}, 4, 1, 3, 2};
        vec[5] = '{'{-1, -1, -1, -2}, -1, -2, 1, -2};

        rst_n          = 1'b0;
        enable         = 1'b0;
        s_if.s_valid   = 1'b0;
        s_if.s_data    = '0;
        m_if.m_ready   = 1'b0;
        #12;
        chk("rst.valid", int'(m_if.m_valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.s_ready", int'(s_if.s_ready), 0);
        chk("rst.max", int'(m_if.m_max), 0);
        chk("rst.min", int'(m_if.m_min), 0);
        chk("rst.pp", int'(m_if.m_pp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.s_ready", int'(s_if.s_ready), 0);

        // Table: one window each, consumer always ready.
        enable       = 1'b1;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < WL; k++) push(vec[i].smp[k]);
            @(negedge clk);
            chk_rec($sformatf("vec%0d", i), vec[i].emax, vec[i].emin,
                    vec[i].epp, vec[i].emean);
            @(negedge clk);
            chk($sformatf("vec%0d.clear", i), int'(m_if.m_valid), 0);
        end

        // Back-pressure: record A stuck, window B stalls on its last sample.
        m_if.m_ready = 1'b0;
        push(5); push(-6); push(7); push(-8);
        push(100); push(200); push(-300);
        @(negedge clk);
        chk_rec("bpA", 7, -8, 15, -1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = DW'(50);
        #1 chk("bp.stall", int'(s_if.s_ready), 0);
        @(negedge clk);
        chk("bp.stall2", int'(s_if.s_ready), 0);
        chk("bp.holdA", int'(m_if.m_max), 7);
        m_if.m_ready = 1'b1;
        #1 chk("bp.release", int'(s_if.s_ready), 1);
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        @(negedge clk);
        chk_rec("bpB", 200, -300, 500, 12);
        @(negedge clk);
        chk("bpB.clear", int'(m_if.m_valid), 0);

        // Partial window discarded by enable drop.
        push(100); push(-100);
        @(negedge clk);
        chk("dis.busy", int'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis.busy0", int'(busy), 0);
        chk("dis.s_ready", int'(s_if.s_ready), 0);
        enable = 1'b1;
        push(1); push(2); push(3); push(4);
        @(negedge clk);
        chk_rec("reen", 4, 1, 3, 2);

        // Window close coinciding with enable fall.
        push(-7); push(3); push(1);
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = DW'(2);
        enable       = 1'b0;
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        @(negedge clk);
        chk_rec("simul", 3, -7, 10, -1);
        chk("simul.s_ready", int'(s_if.s_ready), 0);
        chk("simul.busy", int'(busy), 0);
        @(negedge clk);

        // Async reset mid-window with a record pending.
        m_if.m_ready = 1'b0;
        enable       = 1'b1;
        push(9); push(8); push(7); push(6);
        push(1); push(2);
        @(negedge clk);
        chk("ar.pre_valid", int'(m_if.m_valid), 1);
        chk("ar.pre_busy", int'(busy), 1);
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("ar.valid", int'(m_if.m_valid), 0);
        chk("ar.busy", int'(busy), 0);
        chk("ar.s_ready", int'(s_if.s_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar.idle", int'(s_if.s_ready), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("ar.resume", int'(s_if.s_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
